// File: rtl/bus_pkg.sv
// Shared definitions for the serial slave port: bus widths, mode encoding,
// slave FSM states and the bit-count helper.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_DATA = 3'd6
    } slave_state_e;

    // True when the bit being transferred now completes a field of `width` bits.
    function automatic logic last_bit(input logic [CNT_W-1:0] cnt, input int width);
        return cnt == CNT_W'(width - 1);
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Parameterised left-shifting register with parallel load, serial in at the
// LSB and serial out from the MSB.
module serial_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data,
    output logic             serial_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        // NOTE: default assignment first so every path drives data_d; otherwise a latch is inferred.
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = {data_q[WIDTH-2:0], serial_in};
        end
    end

    // NOTE: the register is reset explicitly because its contents are visible on the bus after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            data_q <= data_d;
        end
    end

    assign data       = data_q;
    assign serial_out = data_q[WIDTH-1];

endmodule

// File: rtl/slave_port.sv
// Serial bus slave: receives address/write data bit-serially, strobes the local
// slave, and returns local read data bit-serially with valid/ready handshakes.
module slave_port
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              mode,
    input  logic              wr_bus,
    input  logic              master_valid,
    output logic              slave_ready,
    input  logic              master_ready,
    output logic              slave_valid,
    output logic              rd_bus,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wr_data,
    output logic              s_wr_en,
    output logic              s_rd_en,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_rd_valid
);

    slave_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;

    logic              wr_xfer;
    logic              rd_xfer;
    logic              addr_shift;
    logic              wd_shift;
    logic              rd_load;
    logic              rd_shift;

    logic [ADDR_W-1:0] addr_sh;
    logic              addr_so;
    logic              wd_so;
    logic [DATA_W-1:0] rd_par;
    logic              rd_so;
    logic              unused_ok;

    assign slave_ready = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_WR_DATA);
    assign slave_valid = (state_q == ST_RD_DATA) && master_ready;
    assign wr_xfer     = master_valid && slave_ready;
    assign rd_xfer     = slave_valid;

    assign s_wr_en = (state_q == ST_WRITE);
    assign s_rd_en = (state_q == ST_RD_REQ);
    assign rd_bus  = (state_q == ST_RD_DATA) && rd_so;
    assign s_addr  = s_addr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        s_addr_d   = s_addr_q;
        addr_shift = 1'b0;
        wd_shift   = 1'b0;
        rd_load    = 1'b0;
        rd_shift   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_xfer) begin
                    mode_d     = mode;
                    addr_shift = 1'b1;
                    cnt_d      = CNT_W'(1);
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (wr_xfer) begin
                    addr_shift = 1'b1;
                    if (last_bit(cnt_q, ADDR_W)) begin
                        // Published address only changes once a full address has arrived.
                        s_addr_d = {addr_sh[ADDR_W-2:0], wr_bus};
                        cnt_d    = '0;
                        state_d  = (mode_q == MODE_READ) ? ST_RD_REQ : ST_WR_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WR_DATA: begin
                if (wr_xfer) begin
                    wd_shift = 1'b1;
                    if (last_bit(cnt_q, DATA_W)) begin
                        cnt_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WRITE:  state_d = ST_IDLE;
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (s_rd_valid) begin
                    rd_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rd_xfer) begin
                    rd_shift = 1'b1;
                    if (last_bit(cnt_q, DATA_W)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mode_q   <= MODE_READ;
            s_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            s_addr_q <= s_addr_d;
        end
    end

    serial_shifter #(.WIDTH(ADDR_W)) u_addr_sh (
        .clk        (clk),
        .rstn       (rstn),
        .load       (1'b0),
        .load_data  ('0),
        .shift_en   (addr_shift),
        .serial_in  (wr_bus),
        .data       (addr_sh),
        .serial_out (addr_so)
    );

    serial_shifter #(.WIDTH(DATA_W)) u_wdata_sh (
        .clk        (clk),
        .rstn       (rstn),
        .load       (1'b0),
        .load_data  ('0),
        .shift_en   (wd_shift),
        .serial_in  (wr_bus),
        .data       (s_wr_data),
        .serial_out (wd_so)
    );

    serial_shifter #(.WIDTH(DATA_W)) u_rdata_sh (
        .clk        (clk),
        .rstn       (rstn),
        .load       (rd_load),
        .load_data  (s_rd_data),
        .shift_en   (rd_shift),
        .serial_in  (1'b0),
        .data       (rd_par),
        .serial_out (rd_so)
    );

    // Shifter taps that this port does not need.
    assign unused_ok = ^{addr_sh[ADDR_W-1], addr_so, wd_so, rd_par};

endmodule
